// File: rtl/cavlc_level_run_combiner.sv
// CAVLC LevelRunCombination: buffers (level, run_before) pairs for one block, then
// walks them from the last coefficient down, writing each level at its zig-zag index.
module cavlc_level_run_combiner #(
    parameter int LEVEL_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic        [4:0]         TotalCoeff,
    input  logic                      start_idx,
    input  logic                      pair_valid,
    output logic                      pair_ready,
    input  logic signed [LEVEL_W-1:0] pair_level,
    input  logic        [3:0]         pair_run,
    output logic                      lrc_active,
    output logic        [3:0]         i_TotalCoeff,
    output logic                      coeff_clr,
    output logic                      coeff_we,
    output logic        [3:0]         coeff_addr,
    output logic signed [LEVEL_W-1:0] coeff_level,
    output logic                      block_done,
    output logic                      err
);

    typedef enum logic [1:0] {IDLE, LOAD, COMBINE, DONE} state_t;

    state_t                    state;
    logic        [4:0]         tcReg;
    logic                      startIdx;
    logic        [3:0]         loadCnt;
    logic signed [5:0]         coeffNum;
    logic signed [LEVEL_W-1:0] levelMem [16];
    logic        [3:0]         runMem   [16];

    logic signed [5:0]         coeffNumNext;
    logic signed [6:0]         addrFull;
    logic                      addrOk;
    logic                      pairAccept;

    function automatic logic addrInRange(input logic signed [6:0] a);
        return (a >= 7'sd0) && (a <= 7'sd15);
    endfunction

    assign pairAccept = pair_valid && pair_ready;

    always_comb begin
        coeffNumNext = coeffNum + $signed({2'b00, runMem[i_TotalCoeff]}) + 6'sd1;
        addrFull     = $signed({coeffNumNext[5], coeffNumNext}) + $signed({6'b0, startIdx});
        addrOk       = addrInRange(addrFull);
        lrc_active   = (state == COMBINE);
        // Out-of-range positions are counted but never reach the coefficient buffer.
        coeff_we     = lrc_active && addrOk;
        coeff_addr   = lrc_active ? addrFull[3:0] : 4'd0;
        coeff_level  = lrc_active ? levelMem[i_TotalCoeff] : '0;
    end

    // Pair storage carries no reset; contents are only read after being loaded.
    always_ff @(posedge clk) begin
        if (state == LOAD && pairAccept) begin
            levelMem[loadCnt] <= pair_level;
            runMem[loadCnt]   <= pair_run;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            tcReg        <= 5'd0;
            startIdx     <= 1'b0;
            loadCnt      <= 4'd0;
            coeffNum     <= -6'sd1;
            pair_ready   <= 1'b0;
            i_TotalCoeff <= 4'd0;
            coeff_clr    <= 1'b0;
            block_done   <= 1'b0;
            err          <= 1'b0;
        end else begin
            coeff_clr  <= 1'b0;
            block_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tcReg     <= TotalCoeff;
                        startIdx  <= start_idx;
                        coeff_clr <= 1'b1;
                        err       <= 1'b0;
                        loadCnt   <= 4'd0;
                        coeffNum  <= -6'sd1;
                        if (TotalCoeff == 5'd0) begin
                            state      <= DONE;
                            block_done <= 1'b1;
                        end else if (TotalCoeff > 5'd16) begin
                            err        <= 1'b1;
                            state      <= DONE;
                            block_done <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            pair_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (pairAccept) begin
                        loadCnt <= loadCnt + 4'd1;
                        if ({1'b0, loadCnt} == tcReg - 5'd1) begin
                            state        <= COMBINE;
                            pair_ready   <= 1'b0;
                            i_TotalCoeff <= loadCnt;
                        end
                    end
                end
                COMBINE: begin
                    coeffNum <= coeffNumNext;
                    if (!addrOk) begin
                        err <= 1'b1;
                    end
                    if (i_TotalCoeff == 4'd0) begin
                        state      <= DONE;
                        block_done <= 1'b1;
                    end else begin
                        i_TotalCoeff <= i_TotalCoeff - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cavlc_level_run_combiner.sv
// Bench for cavlc_level_run_combiner: directed vector table, hand-written sequences
// and randomized blocks checked against a position-accumulation reference model.
module tb_cavlc_level_run_combiner;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic        [4:0]  TotalCoeff;
    logic               start_idx;
    logic               pair_valid;
    logic               pair_ready;
    logic signed [15:0] pair_level;
    logic        [3:0]  pair_run;
    logic               lrc_active;
    logic        [3:0]  i_TotalCoeff;
    logic               coeff_clr;
    logic               coeff_we;
    logic        [3:0]  coeff_addr;
    logic signed [15:0] coeff_level;
    logic               block_done;
    logic               err;

    always #5 clk = ~clk;

    cavlc_level_run_combiner #(.LEVEL_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .TotalCoeff(TotalCoeff),
        .start_idx(start_idx), .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_level(pair_level), .pair_run(pair_run), .lrc_active(lrc_active),
        .i_TotalCoeff(i_TotalCoeff), .coeff_clr(coeff_clr), .coeff_we(coeff_we),
        .coeff_addr(coeff_addr), .coeff_level(coeff_level), .block_done(block_done),
        .err(err)
    );

    int nCmp = 0;
    int nFail = 0;

    logic signed [15:0] lvA [16];
    logic        [3:0]  rnA [16];

    logic signed [15:0] obsMem [16];
    bit                 obsWr  [16];
    int                 obsWrites, obsLrc, obsClr, obsDone, obsRdy, obsCycles, doneAt;
    int                 obsItc [$];
    bit                 rec = 1'b0;
    bit                 errAfter;

    typedef struct packed {
        logic [4:0] tc;
        logic       sidx;
        logic       stall;
        logic       expErr;
        logic [4:0] expWr;
    } vec_t;

    localparam int NV = 8;
    vec_t               tbl [NV];
    logic signed [15:0] tLv [NV][16];
    logic        [3:0]  tRn [NV][16];

    always @(negedge clk) begin
        if (rec) begin
            obsCycles++;
            if (coeff_we) begin
                obsWr[coeff_addr]  = 1'b1;
                obsMem[coeff_addr] = coeff_level;
                obsWrites++;
            end
            if (lrc_active) begin
                obsLrc++;
                obsItc.push_back(int'(i_TotalCoeff));
            end
            if (coeff_clr)  obsClr++;
            if (pair_ready) obsRdy++;
            if (block_done) begin
                obsDone++;
                if (doneAt < 0) doneAt = obsCycles;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clearObs();
        for (int a = 0; a < 16; a++) begin
            obsWr[a]  = 1'b0;
            obsMem[a] = '0;
        end
        obsWrites = 0; obsLrc = 0; obsClr = 0; obsDone = 0; obsRdy = 0;
        obsCycles = 0; doneAt = -1;
        obsItc.delete();
    endtask

    task automatic runBlock(input int tc, input bit sidx, input bit stall);
        int k = 0;
        int guard = 0;
        bit phase = 1'b1;
        bit acc;
        clearObs();
        @(posedge clk); #1;
        start = 1'b1; TotalCoeff = 5'(tc); start_idx = sidx; rec = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (doneAt < 0 && guard < 300) begin
            pair_valid = (k < tc) && (!stall || phase);
            phase      = ~phase;
            pair_level = lvA[k & 15];
            pair_run   = rnA[k & 15];
            acc        = pair_valid && pair_ready;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        pair_valid = 1'b0;
        if (doneAt < 0) check("block_done_timeout", 0, 1);
        errAfter = err;
        @(negedge clk); #1;
        rec = 1'b0;
    endtask

    // Reference: walk levels from index TC-1 down, each position advancing by run+1.
    task automatic checkBlock(input int tc, input bit sidx, input bit stall);
        int  pos = -1;
        int  a;
        int  expVal [16];
        bit  expWr  [16];
        int  expErr = 0;
        int  expWrites = 0;
        bit  valid = (tc >= 1) && (tc <= 16);
        for (int j = 0; j < 16; j++) begin
            expWr[j]  = 1'b0;
            expVal[j] = 0;
        end
        if (tc > 16) expErr = 1;
        if (valid) begin
            for (int i = tc - 1; i >= 0; i--) begin
                pos = pos + int'(rnA[i]) + 1;
                a   = pos + int'(sidx);
                if (a >= 0 && a <= 15) begin
                    expWr[a]  = 1'b1;
                    expVal[a] = int'(lvA[i]);
                    expWrites++;
                end else begin
                    expErr = 1;
                end
            end
        end
        check("coeff_clr_pulses", obsClr, 1);
        check("block_done_pulses", obsDone, 1);
        check("write_count", obsWrites, expWrites);
        check("err", int'(errAfter), expErr);
        check("lrc_active_cycles", obsLrc, valid ? tc : 0);
        if (!stall || !valid) begin
            check("total_cycles", doneAt, valid ? 2 * tc + 2 : 2);
            check("pair_ready_cycles", obsRdy, valid ? tc : 0);
        end
        for (int j = 0; j < 16; j++) begin
            check($sformatf("written_addr%0d", j), int'(obsWr[j]), int'(expWr[j]));
            if (expWr[j]) check($sformatf("level_addr%0d", j), int'(obsMem[j]), expVal[j]);
        end
        for (int j = 0; j < obsItc.size(); j++) begin
            check($sformatf("i_TotalCoeff_step%0d", j), obsItc[j], tc - 1 - j);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_pair_ready"}, int'(pair_ready), 0);
        check({tag, "_lrc_active"}, int'(lrc_active), 0);
        check({tag, "_i_TotalCoeff"}, int'(i_TotalCoeff), 0);
        check({tag, "_coeff_clr"}, int'(coeff_clr), 0);
        check({tag, "_coeff_we"}, int'(coeff_we), 0);
        check({tag, "_coeff_addr"}, int'(coeff_addr), 0);
        check({tag, "_coeff_level"}, int'(coeff_level), 0);
        check({tag, "_block_done"}, int'(block_done), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        int tc;
        int budget;
        int r;
        bit sidx;
        bit stall;

        reset_n = 1'b0; start = 1'b0; TotalCoeff = '0; start_idx = 1'b0;
        pair_valid = 1'b0; pair_level = '0; pair_run = '0;
        for (int i = 0; i < 16; i++) begin lvA[i] = '0; rnA[i] = '0; end
        clearObs();

        for (int v = 0; v < NV; v++) begin
            tbl[v] = '0;
            for (int i = 0; i < 16; i++) begin tLv[v][i] = '0; tRn[v][i] = '0; end
        end
        // T1
        tbl[0] = '{tc: 5'd3, sidx: 1'b0, stall: 1'b0, expErr: 1'b0, expWr: 5'd3};
        tLv[0][0] = 16'sd5;  tRn[0][0] = 4'd1;
        tLv[0][1] = -16'sd2; tRn[0][1] = 4'd0;
        tLv[0][2] = 16'sd1;  tRn[0][2] = 4'd2;
        // T2
        tbl[1] = '{tc: 5'd0, sidx: 1'b0, stall: 1'b0, expErr: 1'b0, expWr: 5'd0};
        // T3
        tbl[2] = '{tc: 5'd16, sidx: 1'b0, stall: 1'b0, expErr: 1'b0, expWr: 5'd16};
        for (int i = 0; i < 16; i++) tLv[2][i] = 16'(i + 1);
        // T4 in range, then one position past the end
        tbl[3] = '{tc: 5'd2, sidx: 1'b1, stall: 1'b0, expErr: 1'b0, expWr: 5'd2};
        tLv[3][0] = 16'sd7; tRn[3][0] = 4'd0; tLv[3][1] = 16'sd3; tRn[3][1] = 4'd13;
        tbl[4] = '{tc: 5'd2, sidx: 1'b1, stall: 1'b0, expErr: 1'b1, expWr: 5'd1};
        tLv[4][0] = 16'sd7; tRn[4][0] = 4'd0; tLv[4][1] = 16'sd3; tRn[4][1] = 4'd14;
        // T5 unstalled and stalled versions of the same block
        for (int v = 5; v <= 6; v++) begin
            tbl[v] = '{tc: 5'd4, sidx: 1'b0, stall: (v == 6), expErr: 1'b0, expWr: 5'd4};
            tLv[v][0] = 16'sd10;  tRn[v][0] = 4'd0;
            tLv[v][1] = -16'sd20; tRn[v][1] = 4'd1;
            tLv[v][2] = 16'sd30;  tRn[v][2] = 4'd0;
            tLv[v][3] = -16'sd40; tRn[v][3] = 4'd2;
        end
        // Illegal coefficient count
        tbl[7] = '{tc: 5'd20, sidx: 1'b0, stall: 1'b0, expErr: 1'b1, expWr: 5'd0};

        #12;
        checkAllZero("reset");
        #5 reset_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 16; i++) begin lvA[i] = tLv[v][i]; rnA[i] = tRn[v][i]; end
            runBlock(int'(tbl[v].tc), tbl[v].sidx, tbl[v].stall);
            checkBlock(int'(tbl[v].tc), tbl[v].sidx, tbl[v].stall);
            check($sformatf("vec%0d_err", v), int'(errAfter), int'(tbl[v].expErr));
            check($sformatf("vec%0d_writes", v), obsWrites, int'(tbl[v].expWr));
            if (v == 0) begin
                check("T1_addr2", int'(obsMem[2]), 1);
                check("T1_addr3", int'(obsMem[3]), -2);
                check("T1_addr5", int'(obsMem[5]), 5);
            end
            if (v == 2) begin
                check("T3_addr0", int'(obsMem[0]), 16);
                check("T3_addr15", int'(obsMem[15]), 1);
            end
        end

        // T6: reset during COMBINE, then a fresh single-coefficient block
        for (int i = 0; i < 16; i++) begin lvA[i] = 16'(100 + i); rnA[i] = '0; end
        clearObs();
        @(posedge clk); #1;
        start = 1'b1; TotalCoeff = 5'd3; start_idx = 1'b0; rec = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pair_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pair_level = lvA[i]; pair_run = rnA[i];
            @(posedge clk); #1;
        end
        pair_valid = 1'b0;
        check("T6_in_combine", int'(lrc_active), 1);
        #2 reset_n = 1'b0;
        #1;
        checkAllZero("T6_async_reset");
        @(posedge clk); @(posedge clk); #3;
        checkAllZero("T6_held_reset");
        reset_n = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        rec = 1'b0;
        check("T6_no_block_done", obsDone, 0);
        lvA[0] = 16'sd9; rnA[0] = 4'd0;
        runBlock(1, 1'b0, 1'b0);
        checkBlock(1, 1'b0, 1'b0);
        check("T6_addr0", int'(obsMem[0]), 9);

        // Randomized blocks
        for (int n = 0; n < 30; n++) begin
            tc    = int'($urandom_range(1, 16));
            sidx  = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            budget = 16 - tc + int'($urandom_range(0, 2));
            for (int i = 0; i < 16; i++) begin
                lvA[i] = 16'($urandom);
                rnA[i] = '0;
            end
            for (int i = tc - 1; i >= 0; i--) begin
                r = int'($urandom_range(0, (budget > 15) ? 15 : budget));
                rnA[i] = 4'(r);
                budget -= r;
            end
            runBlock(tc, sidx, stall);
            checkBlock(tc, sidx, stall);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
